// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operand/result handshake bundle for seq_alu
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       ALUControl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             err;

   modport master (
      output in_valid, a, b, ALUControl, out_ready,
      input  in_ready, out_valid, result, zero, carry, overflow, err
   );

   modport slave (
      input  in_valid, a, b, ALUControl, out_ready,
      output in_ready, out_valid, result, zero, carry, overflow, err
   );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU with registered flags; SEQ_ALU_MUL_EN adds an iterative shift-add multiplier
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic  clk,
   input  logic  reset,
   seq_alu_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DONE = 2'd2;
`ifdef SEQ_ALU_MUL_EN
   localparam logic [1:0] BUSY = 2'd1;
   localparam int         CNT_W = $clog2(WIDTH);
`endif

   logic [1:0]       state;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             carry_q;
   logic             overflow_q;
   logic             err_q;
   logic             accept;

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] c_res;
   logic             c_carry;
   logic             c_ovf;
   logic             c_err;
`ifdef SEQ_ALU_MUL_EN
   logic             c_mul;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt;
`endif

   assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.err       = err_q;
   assign accept        = bus.in_valid && bus.in_ready;

   // Single-cycle datapath works straight off the bus; it is only sampled on accept.
   always_comb begin
      sum_ext = '0;
      c_res   = '0;
      c_carry = 1'b0;
      c_ovf   = 1'b0;
      c_err   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
      c_mul   = 1'b0;
`endif
      case (bus.ALUControl)
         3'b000: begin
            sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
            c_res   = sum_ext[WIDTH-1:0];
            c_carry = sum_ext[WIDTH];
            c_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (c_res[WIDTH-1] != bus.a[WIDTH-1]);
         end
         3'b001: begin
            sum_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
            c_res   = sum_ext[WIDTH-1:0];
            c_carry = sum_ext[WIDTH];
            c_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (c_res[WIDTH-1] != bus.a[WIDTH-1]);
         end
         3'b010: c_res = bus.a & bus.b;
         3'b011: c_res = bus.a ^ bus.b;
         3'b100: c_res = bus.a | bus.b;
         3'b101: c_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
`ifdef SEQ_ALU_MUL_EN
         3'b110: c_mul = 1'b1;
`endif
         default: c_err = 1'b1;
      endcase
   end

`ifdef SEQ_ALU_MUL_EN
   assign acc_nxt = mplier[0] ? acc + mcand : acc;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         result_q   <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         err_q      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         mcand      <= '0;
         mplier     <= '0;
         acc        <= '0;
         cnt        <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                  if (c_mul) begin
                     mcand  <= bus.a;
                     mplier <= bus.b;
                     acc    <= '0;
                     cnt    <= '0;
                     state  <= BUSY;
                  end else begin
`endif
                     result_q   <= c_res;
                     zero_q     <= (c_res == '0);
                     carry_q    <= c_carry;
                     overflow_q <= c_ovf;
                     err_q      <= c_err;
                     state      <= DONE;
`ifdef SEQ_ALU_MUL_EN
                  end
`endif
               end else if (state == DONE && bus.out_ready) begin
                  state <= IDLE;
               end
            end
`ifdef SEQ_ALU_MUL_EN
            // One multiplier bit per cycle; the final iteration writes the result directly.
            BUSY: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH-1)) begin
                  result_q   <= acc_nxt;
                  zero_q     <= (acc_nxt == '0);
                  carry_q    <= 1'b0;
                  overflow_q <= 1'b0;
                  err_q      <= 1'b0;
                  state      <= DONE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu (directed vectors, SEQ_ALU_MUL_EN aware)
module tb_seq_alu;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(32)) bus();
   seq_alu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef SEQ_ALU_MUL_EN
   localparam bit MUL_ON  = 1'b1;
   localparam int MUL_LAT = 33;
`else
   localparam bit MUL_ON  = 1'b0;
   localparam int MUL_LAT = 1;
`endif

   typedef struct {
      string       name;
      logic [31:0] r;
      logic        z;
      logic        c;
      logic        o;
      logic        e;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per completed output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output result=%h err=%b", bus.result, bus.err);
         end else begin
            e = sb.pop_front();
            check(e.name, {bus.result, bus.zero, bus.carry, bus.overflow, bus.err},
                  {e.r, e.z, e.c, e.o, e.e});
         end
      end
   end

   task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input logic z,
                        input logic c, input logic o, input logic e, output int waited);
      int n = 0;
      bus.in_valid   = 1'b1;
      bus.ALUControl = op;
      bus.a          = a;
      bus.b          = b;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s accept_timeout waited=%0d required<200", name, n);
      end else begin
         sb.push_back('{name, r, z, c, o, e});
      end
      @(posedge clk);
      #1;
      bus.in_valid   = 1'b0;
      bus.a          = $urandom;
      bus.b          = $urandom;
      bus.ALUControl = 3'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int n;
      bit seen;
      reset          = 1'b1;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b1;
      bus.a          = '0;
      bus.b          = '0;
      bus.ALUControl = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_result", bus.result, 0);
      check("rst_flags", {bus.zero, bus.carry, bus.overflow, bus.err}, 0);
      reset = 1'b0;

      issue("add_20_10",   3'b000, 32'd20,        32'd10, 32'd30,        0, 0, 0, 0, w);
      issue("sub_10_20",   3'b001, 32'd10,        32'd20, 32'hFFFFFFF6,  0, 0, 0, 0, w);
      issue("sub_20_20",   3'b001, 32'd20,        32'd20, 32'd0,         1, 1, 0, 0, w);
      issue("add_ovf",     3'b000, 32'h7FFFFFFF,  32'd1,  32'h80000000,  0, 0, 1, 0, w);
      issue("add_carry",   3'b000, 32'hFFFFFFFF,  32'd1,  32'd0,         1, 1, 0, 0, w);
      issue("sub_ovf",     3'b001, 32'h80000000,  32'd1,  32'h7FFFFFFF,  0, 1, 1, 0, w);
      issue("slt_neg",     3'b101, 32'hFFFFFFFF,  32'd1,  32'd1,         0, 0, 0, 0, w);
      issue("slt_pos",     3'b101, 32'd10,        32'd1,  32'd0,         1, 0, 0, 0, w);
      issue("and_10_10",   3'b010, 32'd10,        32'd10, 32'd10,        0, 0, 0, 0, w);
      issue("xor_10_1",    3'b011, 32'd10,        32'd1,  32'd11,        0, 0, 0, 0, w);
      issue("or_8_1",      3'b100, 32'd8,         32'd1,  32'd9,         0, 0, 0, 0, w);
      issue("illegal_111", 3'b111, 32'd5,         32'd3,  32'd0,         1, 0, 0, 1, w);
      drain();

      // MUL: latency and in_ready low while the multiplier iterates.
      issue("mul_7_6", 3'b110, 32'd7, 32'd6, MUL_ON ? 32'd42 : 32'd0, !MUL_ON, 0, 0, !MUL_ON, w);
      n = 1;
      seen = 1'b0;
      while (bus.out_valid !== 1'b1 && n < 100) begin
         if (bus.in_ready !== 1'b0) seen = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      check("mul_latency", n, MUL_LAT);
      check("busy_in_ready_low", seen, 0);
      issue("mul_neg3_5", 3'b110, 32'hFFFFFFFD, 32'd5, MUL_ON ? 32'hFFFFFFF1 : 32'd0,
            !MUL_ON, 0, 0, !MUL_ON, w);
      drain();

      // Back-pressure: hold result, then a same-cycle hand-over.
      bus.out_ready = 1'b0;
      issue("bp_add", 3'b000, 32'd5, 32'd6, 32'd11, 0, 0, 0, 0, w);
      for (int k = 0; k < 5; k++) begin
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_result", bus.result, 11);
         check("bp_flags", {bus.zero, bus.carry, bus.overflow, bus.err}, 0);
         check("bp_in_ready", bus.in_ready, 0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      issue("b2b_sub", 3'b001, 32'd20, 32'd20, 32'd0, 1, 1, 0, 0, w);
      check("b2b_same_cycle_wait", w, 0);
      drain();

      // Reset in the middle of a MUL discards it.
      issue("mul_rst", 3'b110, 32'd7, 32'd6, MUL_ON ? 32'd42 : 32'd0, !MUL_ON, 0, 0, !MUL_ON, w);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_result", bus.result, 0);
      seen = 1'b0;
      repeat (40) begin
         if (bus.out_valid === 1'b1) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      check("rst_no_out_valid", seen, 0);
      issue("add_after_rst", 3'b000, 32'd20, 32'd10, 32'd30, 0, 0, 0, 0, w);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
